notconcat_unpack: RTL and testbench
===================================

// Module: notconcat_unpack
// PURPOSE
//  Receive-side counterpart of the notconcat packer. The packer forms {~a,~b,~c,~d}.
//  This block accepts packed words on a valid/ready stream and holds each word.
//  It re-inverts every byte field and emits the fields one per cycle, a first, on a
//  byte stream. Sits between the packed-word bus and byte-wide consumers in the cosim.
// PARAMETERS
//  LANES   4   byte fields per packed word (>=2)
//  BYTE_W  8   width of one field
//  CNT_W   16  width of the completed-word counter
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              packed word offered
//  in_ready   out  1              block can take a packed word this cycle
//  in_data    in   LANES*BYTE_W   packed word {~f0,~f1,...,~f(LANES-1)}, f0 in MSBs
//  out_valid  out  1              recovered byte available
//  out_ready  in   1              consumer takes the byte this cycle
//  out_data   out  BYTE_W         recovered field, non-inverted
//  out_last   out  1              out_data is the final field (f(LANES-1)) of its word
//  words_done out  CNT_W          count of fully emitted words
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, idx=0, hold reg=0, out_valid=0, out_data=0,
//    out_last=0, words_done=0, in_ready=1. All resets are immediate; rst wins over all.
//  - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//    - out_data and out_last are stable while out_valid=1 and out_ready=0.
//  - State IDLE: out_valid=0, in_ready=1.
//    - on in_fire: capture in_data into hold reg, idx<=0, go to EMIT.
//  - State EMIT: out_valid=1, out_data = ~hold[(LANES-idx)*BYTE_W-1 -: BYTE_W].
//    - out_last = (idx==LANES-1).
//    - out_fire with idx<LANES-1: idx<=idx+1.
//    - out_fire with idx==LANES-1: words_done<=words_done+1, which wraps at 2^CNT_W.
//        in_fire in the same cycle: load new word, idx<=0, stay EMIT (back-to-back).
//        no in_fire: go to IDLE.
//  - in_ready = (state==IDLE) | (state==EMIT & out_ready & idx==LANES-1).
//    - Combinational from out_ready; no other comb paths from input to output.
//  - Latency: word accepted at edge N -> field f0 valid after edge N.
//  - Throughput: 1 byte/cycle; LANES cycles/word with no bubble between words.
//  - in_valid while in_ready=0 is ignored; the upstream must hold it.
//  - Reset mid-word: the partially emitted word is discarded and words_done is not
//    incremented.
//  - out_valid may assert without out_ready.
//    - It never deasserts without out_fire except on reset.
// TESTING
//  - Reset: assert rst mid-cycle -> out_valid=0, in_ready=1, words_done=0 with no clock edge.
//  - Single word: in_data=32'h0F1E2D3C, out_ready=1 -> out_data F0,E1,D2,C3 on 4 consecutive
//    cycles; out_last only on C3; words_done=1.
//  - Backpressure: same word, out_ready low 3 cycles during field E1 -> E1 held stable;
//    order unchanged; in_ready=0 throughout.
//  - Back-to-back: words 32'hFFFFFFFF then 32'h00000000 with in_valid held ->
//    00,00,00,00,FF,FF,FF,FF with no idle cycle; words_done=2.
//  - Reset mid-word: rst after 2 fields emitted -> output idle, words_done unchanged (0).
//    - The next word restarts at f0.
//  - Wrap: CNT_W=2, 5 words -> words_done sequence 1,2,3,0,1.
//  - Round trip: packer output for a=8'hA5,b=8'h3C,c=8'h00,d=8'hFF fed in ->
//    A5,3C,00,FF recovered.

Source files
------------

// File: rtl/notconcat_unpack.sv
// Unpacks a word of inverted byte fields {~f0,...,~f(LANES-1)} and streams the
// recovered fields out one per cycle, f0 first, with a completed-word counter.
module notconcat_unpack #(
    parameter int LANES  = 4,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*BYTE_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W-1:0]         out_data,
    output logic                      out_last,
    output logic [CNT_W-1:0]          words_done
);
    localparam int W     = LANES * BYTE_W;
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               at_last;
    logic               in_fire;
    logic               out_fire;
    logic [W-1:0]       field_sh;

    always_comb begin
        at_last    = (idx_q == LAST_IDX);
        out_valid  = (state_q == EMIT);
        // Accepting on the last field's handshake gives back-to-back words with no bubble.
        in_ready   = (state_q == IDLE) | ((state_q == EMIT) & out_ready & at_last);
        in_fire    = in_valid & in_ready;
        out_fire   = out_valid & out_ready;
        field_sh   = hold_q >> (BYTE_W * (LANES - 1 - int'(idx_q)));
        out_data   = out_valid ? ~field_sh[BYTE_W-1:0] : '0;
        out_last   = out_valid & at_last;
        words_done = cnt_q;

        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    hold_d  = in_data;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (in_fire) begin
                            hold_d = in_data;
                            idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_notconcat_unpack.sv
// Randomized and directed bench for notconcat_unpack: a byte-queue model predicts
// every output each cycle; directed sequences pin literal expectations.
module tb_notconcat_unpack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] words_done;

    logic        w_in_ready, w_out_valid, w_out_last;
    logic [7:0]  w_out_data;
    logic [1:0]  w_words_done;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } ent_t;

    typedef struct {
        logic [7:0] b;
        bit         last;
        int         cyc;
    } rx_t;

    ent_t        mq[$];
    rx_t         rx[$];
    int unsigned m_cnt = 0;

    notconcat_unpack #(.LANES(4), .BYTE_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .words_done(words_done)
    );

    notconcat_unpack #(.LANES(4), .BYTE_W(8), .CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .out_last(w_out_last), .words_done(w_words_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: the word is just a queue of recovered bytes waiting to leave.
    initial begin
        bit         m_ready;
        bit         fire_in;
        ent_t       e;
        logic [31:0] w;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_cnt = 0;
            end else begin
                cyc++;
                m_ready = (mq.size() == 0) || (mq.size() == 1 && out_ready);
                fire_in = in_valid && m_ready;
                w = in_data;
                if (mq.size() > 0 && out_ready) begin
                    if (mq[0].last) m_cnt++;
                    void'(mq.pop_front());
                end
                if (fire_in) begin
                    for (int i = 0; i < 4; i++) begin
                        e.b    = ~w[31-8*i -: 8];
                        e.last = (i == 3);
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        bit  exp_ready;
        rx_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_ready = (mq.size() == 0) || (mq.size() == 1 && out_ready);
                check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
                check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
                check("words_done", {16'd0, words_done}, m_cnt & 32'hFFFF);
                check("wrap_words_done", {30'd0, w_words_done}, m_cnt & 32'h3);
                if (mq.size() > 0) begin
                    check("out_data", {24'd0, out_data}, {24'd0, mq[0].b});
                    check("out_last", {31'd0, out_last}, {31'd0, mq[0].last});
                end
                if (out_valid && out_ready) begin
                    r.b = out_data; r.last = out_last; r.cyc = cyc;
                    rx.push_back(r);
                end
            end
        end
    end

    task automatic offer(input logic [31:0] w);
        bit ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        check("offer_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string name, input logic [31:0] bytes_exp);
        logic [31:0] be;
        be = bytes_exp;
        check({name, "_count"}, rx.size(), 32'd4);
        if (rx.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check({name, "_byte"}, {24'd0, rx[i].b}, {24'd0, be[31-8*i -: 8]});
                check({name, "_last"}, {31'd0, rx[i].last}, {31'd0, i == 3});
            end
        end
    endtask

    initial begin
        int wexp[5] = '{1, 2, 3, 0, 1};
        bit ok;

        // Reset state
        drain(2);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_words_done", {16'd0, words_done}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single word
        rx.delete();
        offer(32'h0F1E2D3C); in_valid = 1'b0;
        drain(6);
        check_rx("single", 32'hF0E1D2C3);
        check("single_words_done", {16'd0, words_done}, 32'd1);

        // Backpressure on E1
        rx.delete();
        offer(32'h0F1E2D3C); in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_data", {24'd0, out_data}, 32'hE1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain(6);
        check_rx("bp", 32'hF0E1D2C3);
        check("bp_words_done", {16'd0, words_done}, 32'd2);

        // Back-to-back with in_valid held
        rx.delete();
        offer(32'hFFFFFFFF);
        offer(32'h00000000);
        in_valid = 1'b0;
        drain(8);
        check("b2b_count", rx.size(), 32'd8);
        if (rx.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check("b2b_byte", {24'd0, rx[i].b}, (i < 4) ? 32'h00 : 32'hFF);
            check("b2b_no_bubble", rx[7].cyc - rx[0].cyc, 32'd7);
        end
        check("b2b_words_done", {16'd0, words_done}, 32'd4);

        // Reset mid-word after two fields
        rx.delete();
        offer(32'h0F1E2D3C); in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = (rx.size() >= 2);
        end
        check("midrst_two_fields", {31'd0, ok}, 32'd1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_words_done", {16'd0, words_done}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        rx.delete();
        offer(32'h0F1E2D3C); in_valid = 1'b0;
        drain(6);
        check_rx("restart", 32'hF0E1D2C3);

        // Counter wrap on the 2-bit instance; first word is the packer round trip
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx.delete();
            offer((i == 0) ? 32'h5AC3FF00 : $urandom);
            in_valid = 1'b0;
            drain(6);
            if (i == 0) check_rx("roundtrip", 32'hA53C00FF);
            check("wrap_seq", {30'd0, w_words_done}, wexp[i]);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(10);
        check("final_idle", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
